// File: rtl/cfu_pkg.sv
// Shared CFU-LI defaults and status encodings for the CFU-L2 adapters.
`timescale 1ns/1ps
package cfu_pkg;

    localparam int unsigned CFU_L2_DEF_CFU_ID_W   = 1;
    localparam int unsigned CFU_L2_DEF_STATE_ID_W = 1;
    localparam int unsigned CFU_L2_DEF_FUNC_ID_W  = 10;
    localparam int unsigned CFU_L2_DEF_INSN_W     = 0;
    localparam int unsigned CFU_L2_DEF_DATA_W     = 32;
    localparam int unsigned CFU_L2_DEF_STATUS_W   = 3;

    localparam logic [CFU_L2_DEF_STATUS_W-1:0] CFU_OK    = 3'd0;
    localparam logic [CFU_L2_DEF_STATUS_W-1:0] CFU_ERROR = 3'd1;

    // A zero-width field (e.g. no insn bits) still needs a one-bit port.
    function automatic int unsigned width1(input int unsigned w);
        return (w > 0) ? w : 1;
    endfunction

endpackage

// File: rtl/queue.sv
// Simple synchronous FIFO with registered head; no fall-through on push.
`timescale 1ns/1ps
module queue #(
    parameter int unsigned W = 8,
    parameter int unsigned N = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    output logic [W-1:0] head,
    output logic         valid,
    output logic         full
);

    localparam int unsigned PTR_W = (N > 1) ? $clog2(N) : 1;
    localparam int unsigned CNT_W = $clog2(N + 1);

    logic [W-1:0]     mem [N];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [CNT_W-1:0] count;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(N - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign valid   = (count != '0);
    assign full    = (count == CNT_W'(N));
    assign do_push = push && !full;
    assign do_pop  = pop && valid;
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < N; i++) begin
                mem[i] <= '0;
            end
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= next_ptr(wr_ptr);
            end
            if (do_pop) begin
                rd_ptr <= next_ptr(rd_ptr);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/cfu_l2_target_shim.sv
// Wraps a fixed-latency CFU-L1 leaf as a CFU-L2 target: credits bound in-flight
// work so every L1 response has a FIFO slot while the upstream switch stalls.
`timescale 1ns/1ps
module cfu_l2_target_shim
    import cfu_pkg::*;
#(
    parameter int unsigned CFU_CFU_ID_W   = CFU_L2_DEF_CFU_ID_W,
    parameter int unsigned CFU_STATE_ID_W = CFU_L2_DEF_STATE_ID_W,
    parameter int unsigned CFU_FUNC_ID_W  = CFU_L2_DEF_FUNC_ID_W,
    parameter int unsigned CFU_INSN_W     = CFU_L2_DEF_INSN_W,
    parameter int unsigned CFU_DATA_W     = CFU_L2_DEF_DATA_W,
    parameter int unsigned CFU_STATUS_W   = CFU_L2_DEF_STATUS_W,
    parameter int unsigned LATENCY        = 1,
    parameter int unsigned N_RESPS        = 4
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            clk_en,
    input  logic                            t_req_valid,
    output logic                            t_req_ready,
    input  logic [CFU_CFU_ID_W-1:0]         t_req_cfu,
    input  logic [CFU_STATE_ID_W-1:0]       t_req_state,
    input  logic [CFU_FUNC_ID_W-1:0]        t_req_func,
    input  logic [width1(CFU_INSN_W)-1:0]   t_req_insn,
    input  logic [CFU_DATA_W-1:0]           t_req_data0,
    input  logic [CFU_DATA_W-1:0]           t_req_data1,
    output logic                            t_resp_valid,
    input  logic                            t_resp_ready,
    output logic [CFU_STATUS_W-1:0]         t_resp_status,
    output logic [CFU_DATA_W-1:0]           t_resp_data,
    output logic                            l1_clk_en,
    output logic                            l1_req_valid,
    output logic [CFU_STATE_ID_W-1:0]       l1_req_state,
    output logic [CFU_FUNC_ID_W-1:0]        l1_req_func,
    output logic [width1(CFU_INSN_W)-1:0]   l1_req_insn,
    output logic [CFU_DATA_W-1:0]           l1_req_data0,
    output logic [CFU_DATA_W-1:0]           l1_req_data1,
    input  logic                            l1_resp_valid,
    input  logic [CFU_STATUS_W-1:0]         l1_resp_status,
    input  logic [CFU_DATA_W-1:0]           l1_resp_data
);

    localparam int unsigned N_PEND_W = $clog2(N_RESPS + 1);
    localparam int unsigned RESP_W   = CFU_STATUS_W + CFU_DATA_W;

    typedef logic [N_PEND_W-1:0] n_pend_t;

    typedef struct packed {
        logic [CFU_STATUS_W-1:0] status;
        logic [CFU_DATA_W-1:0]   data;
    } resp_t;

    n_pend_t            n_pend;
    logic               proto_err;
    logic [LATENCY-1:0] pipe_valid;
    logic [LATENCY-1:0] pipe_bad;
    logic               req_fire;
    logic               req_good;
    logic               resp_fire;
    logic               exit_valid;
    logic               exit_bad;
    logic               resp_push;
    logic               fifo_valid;
    logic               fifo_full;
    resp_t              push_resp;
    resp_t              head_resp;

    // Ready is held low during reset so nothing is accepted before release.
    assign t_req_ready = rst && clk_en && (n_pend != n_pend_t'(N_RESPS));
    assign req_fire    = t_req_valid && t_req_ready;
    assign req_good    = (t_req_cfu == '0);
    assign resp_fire   = clk_en && fifo_valid && t_resp_ready;

    assign l1_clk_en    = clk_en;
    assign l1_req_valid = req_fire && req_good;
    assign l1_req_state = t_req_state;
    assign l1_req_func  = t_req_func;
    assign l1_req_insn  = t_req_insn;
    assign l1_req_data0 = t_req_data0;
    assign l1_req_data1 = t_req_data1;

    assign exit_valid = pipe_valid[LATENCY-1];
    assign exit_bad   = pipe_bad[LATENCY-1];
    assign resp_push  = clk_en && exit_valid && !fifo_full;

    // Bad tokens and missing L1 responses both turn into error responses.
    always_comb begin
        push_resp.status = CFU_STATUS_W'(CFU_ERROR);
        push_resp.data   = '0;
        if (!exit_bad && l1_resp_valid) begin
            push_resp.status = l1_resp_status;
            push_resp.data   = l1_resp_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            n_pend     <= '0;
            pipe_valid <= '0;
            pipe_bad   <= '0;
            proto_err  <= 1'b0;
        end else if (clk_en) begin
            case ({req_fire, resp_fire})
                2'b10:   n_pend <= n_pend + n_pend_t'(1);
                2'b01:   n_pend <= n_pend - n_pend_t'(1);
                default: n_pend <= n_pend;
            endcase
            for (int unsigned i = 1; i < LATENCY; i++) begin
                pipe_valid[i] <= pipe_valid[i-1];
                pipe_bad[i]   <= pipe_bad[i-1];
            end
            pipe_valid[0] <= req_fire;
            pipe_bad[0]   <= req_fire && !req_good;
            if (exit_valid && !exit_bad && !l1_resp_valid) begin
                proto_err <= 1'b1;
            end
        end
    end

    queue #(
        .W (RESP_W),
        .N (N_RESPS)
    ) u_resp_q (
        .clk       (clk),
        .rst       (!rst),
        .push      (resp_push),
        .push_data (push_resp),
        .pop       (resp_fire),
        .head      (head_resp),
        .valid     (fifo_valid),
        .full      (fifo_full)
    );

    assign t_resp_valid  = fifo_valid;
    assign t_resp_status = head_resp.status;
    assign t_resp_data   = head_resp.data;

endmodule

// File: tb/tb_cfu_l2_target_shim.sv
// Randomized and directed bench for cfu_l2_target_shim with an age-based
// reference model of the in-order response stream and a fixed-latency L1 leaf.
`timescale 1ns/1ps
module tb_cfu_l2_target_shim;
    import cfu_pkg::*;

    localparam int unsigned LAT = 2;
    localparam int unsigned NR  = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        clk_en;
    logic        t_req_valid;
    logic        t_req_ready;
    logic [0:0]  t_req_cfu;
    logic [0:0]  t_req_state;
    logic [9:0]  t_req_func;
    logic [0:0]  t_req_insn;
    logic [31:0] t_req_data0;
    logic [31:0] t_req_data1;
    logic        t_resp_valid;
    logic        t_resp_ready;
    logic [2:0]  t_resp_status;
    logic [31:0] t_resp_data;
    logic        l1_clk_en;
    logic        l1_req_valid;
    logic [0:0]  l1_req_state;
    logic [9:0]  l1_req_func;
    logic [0:0]  l1_req_insn;
    logic [31:0] l1_req_data0;
    logic [31:0] l1_req_data1;
    logic        l1_resp_valid;
    logic [2:0]  l1_resp_status;
    logic [31:0] l1_resp_data;

    cfu_l2_target_shim #(.LATENCY(LAT), .N_RESPS(NR)) dut (
        .clk(clk), .rst(rst), .clk_en(clk_en),
        .t_req_valid(t_req_valid), .t_req_ready(t_req_ready),
        .t_req_cfu(t_req_cfu), .t_req_state(t_req_state), .t_req_func(t_req_func),
        .t_req_insn(t_req_insn), .t_req_data0(t_req_data0), .t_req_data1(t_req_data1),
        .t_resp_valid(t_resp_valid), .t_resp_ready(t_resp_ready),
        .t_resp_status(t_resp_status), .t_resp_data(t_resp_data),
        .l1_clk_en(l1_clk_en), .l1_req_valid(l1_req_valid),
        .l1_req_state(l1_req_state), .l1_req_func(l1_req_func), .l1_req_insn(l1_req_insn),
        .l1_req_data0(l1_req_data0), .l1_req_data1(l1_req_data1),
        .l1_resp_valid(l1_resp_valid), .l1_resp_status(l1_resp_status),
        .l1_resp_data(l1_resp_data)
    );

    always #5 clk = ~clk;

    typedef struct {
        int unsigned age;
        logic [2:0]  st;
        logic [31:0] d;
    } exp_t;

    typedef struct {
        int unsigned age;
        logic        withhold;
        logic [2:0]  st;
        logic [31:0] d;
    } l1_t;

    exp_t        mq[$];
    l1_t         l1q[$];
    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;
    logic        m_proto = 1'b0;
    logic        withhold = 1'b0;
    logic        spurious = 1'b0;
    logic        s_resp_valid;
    logic [31:0] s_resp_data;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic drive_req(input logic v, input logic c, input logic [31:0] a,
                             input logic [31:0] b, input logic wh);
        t_req_valid = v;
        t_req_cfu   = c;
        t_req_data0 = a;
        t_req_data1 = b;
        t_req_func  = 10'($urandom);
        t_req_state = 1'($urandom);
        t_req_insn  = 1'($urandom);
        withhold    = wh;
    endtask

    // One clock cycle: drive the L1 leaf, check at negedge, advance the model at posedge.
    task automatic step();
        logic exp_ready, exp_rv, req_acc, resp_acc, l1_due;
        l1_due = (l1q.size() > 0) && (l1q[0].age == LAT);
        if (l1_due && !l1q[0].withhold) begin
            l1_resp_valid  = 1'b1;
            l1_resp_status = l1q[0].st;
            l1_resp_data   = l1q[0].d;
        end else if (!l1_due && spurious) begin
            l1_resp_valid  = 1'b1;
            l1_resp_status = 3'($urandom);
            l1_resp_data   = $urandom;
        end else begin
            l1_resp_valid  = 1'b0;
            l1_resp_status = '0;
            l1_resp_data   = '0;
        end
        @(negedge clk);
        exp_ready = rst && clk_en && (mq.size() != NR);
        exp_rv    = rst && (mq.size() > 0) && (mq[0].age >= LAT + 1);
        req_acc   = t_req_valid && exp_ready;
        resp_acc  = exp_rv && t_resp_ready && clk_en;
        check("t_req_ready", 64'(t_req_ready), 64'(exp_ready));
        check("t_resp_valid", 64'(t_resp_valid), 64'(exp_rv));
        check("l1_clk_en", 64'(l1_clk_en), 64'(clk_en));
        check("l1_req_valid", 64'(l1_req_valid), 64'(req_acc && (t_req_cfu == 1'b0)));
        if (req_acc && t_req_cfu == 1'b0) begin
            check("l1_req_data0", 64'(l1_req_data0), 64'(t_req_data0));
            check("l1_req_data1", 64'(l1_req_data1), 64'(t_req_data1));
            check("l1_req_func", 64'(l1_req_func), 64'(t_req_func));
        end
        if (exp_rv && t_resp_valid) begin
            check("resp_status", 64'(t_resp_status), 64'(mq[0].st));
            check("resp_data", 64'(t_resp_data), 64'(mq[0].d));
        end
        check("fifo_overflow", 64'(dut.resp_push && dut.fifo_full), 64'(0));
        s_resp_valid = t_resp_valid;
        s_resp_data  = t_resp_data;
        @(posedge clk);
        if (rst && clk_en) begin
            if (l1_due) begin
                if (l1q[0].withhold) m_proto = 1'b1;
                void'(l1q.pop_front());
            end
            if (resp_acc) void'(mq.pop_front());
            foreach (mq[i]) mq[i].age++;
            foreach (l1q[i]) l1q[i].age++;
            if (req_acc) begin
                l1_t  l;
                exp_t e;
                l.age = 1; l.withhold = withhold; l.st = 3'($urandom);
                l.d = t_req_data0 + t_req_data1;
                e.age = 1;
                if (t_req_cfu != 1'b0 || withhold) begin
                    e.st = CFU_ERROR; e.d = '0;
                end else begin
                    e.st = l.st; e.d = l.d;
                end
                mq.push_back(e);
                if (t_req_cfu == 1'b0) l1q.push_back(l);
            end
        end
        #1;
    endtask

    task automatic wait_resp(output int unsigned cyc);
        cyc = 0;
        for (int i = 0; i < 40; i++) begin
            step();
            cyc++;
            if (s_resp_valid) return;
        end
        check("resp_timeout", 64'(0), 64'(1));
    endtask

    initial begin
        int unsigned cyc;
        rst = 1'b0; clk_en = 1'b1; t_resp_ready = 1'b0;
        l1_resp_valid = 1'b0; l1_resp_status = '0; l1_resp_data = '0;
        drive_req(1'b1, 1'b0, 32'd1, 32'd2, 1'b0);
        #2;
        check("rst_ready", 64'(t_req_ready), 64'(0));
        check("rst_resp_valid", 64'(t_resp_valid), 64'(0));
        check("rst_resp_data", 64'(t_resp_data), 64'(0));
        check("rst_l1_req_valid", 64'(l1_req_valid), 64'(0));
        step(); step();
        rst = 1'b1;

        // Single request: 5 + 7 comes back after LATENCY+1 cycles.
        t_resp_ready = 1'b1;
        drive_req(1'b1, 1'b0, 32'd5, 32'd7, 1'b0);
        step();
        drive_req(1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
        wait_resp(cyc);
        check("single_latency", 64'(cyc), 64'(LAT + 1));
        check("single_data", 64'(s_resp_data), 64'(12));
        repeat (3) step();

        // Fill all credits with the response side stalled, then drain in order.
        t_resp_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive_req(1'b1, 1'b0, 32'(100 * i), 32'(i), 1'b0);
            step();
        end
        check("full_ready", 64'(t_req_ready), 64'(0));
        drive_req(1'b1, 1'b0, 32'd9, 32'd9, 1'b0);
        repeat (4) step();
        t_resp_ready = 1'b1;
        repeat (4) step();
        drive_req(1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
        repeat (8) step();

        // Bad CFU id sandwiched between good requests.
        for (int i = 0; i < 3; i++) begin
            drive_req(1'b1, 1'(i == 1), 32'(i + 40), 32'd3, 1'b0);
            step();
        end
        drive_req(1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
        repeat (6) step();

        // Missing L1 response, then spurious L1 valids with nothing due.
        check("proto_err_clear", 64'(dut.proto_err), 64'(0));
        drive_req(1'b1, 1'b0, 32'd11, 32'd22, 1'b1);
        step();
        drive_req(1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
        repeat (5) step();
        spurious = 1'b1;
        repeat (6) step();
        spurious = 1'b0;
        check("proto_err_set", 64'(dut.proto_err), 64'(1));
        check("proto_err_model", 64'(m_proto), 64'(1));

        // Asynchronous reset with work in flight and in the FIFO.
        t_resp_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive_req(1'b1, 1'b0, 32'(i + 1), 32'd1, 1'b0);
            step();
        end
        drive_req(1'b1, 1'b0, 32'd4, 32'd4, 1'b0);
        #2;
        rst = 1'b0;
        #1;
        check("arst_resp_valid", 64'(t_resp_valid), 64'(0));
        check("arst_resp_status", 64'(t_resp_status), 64'(0));
        check("arst_resp_data", 64'(t_resp_data), 64'(0));
        check("arst_l1_req_valid", 64'(l1_req_valid), 64'(0));
        check("arst_ready", 64'(t_req_ready), 64'(0));
        check("arst_n_pend", 64'(dut.n_pend), 64'(0));
        check("arst_proto_err", 64'(dut.proto_err), 64'(0));
        mq.delete(); l1q.delete(); m_proto = 1'b0;
        step(); step();
        rst = 1'b1;
        t_resp_ready = 1'b1;
        drive_req(1'b1, 1'b0, 32'd30, 32'd12, 1'b0);
        step();
        check("post_rst_n_pend", 64'(dut.n_pend), 64'(1));
        drive_req(1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
        wait_resp(cyc);
        check("post_rst_latency", 64'(cyc), 64'(LAT + 1));
        check("post_rst_data", 64'(s_resp_data), 64'(42));
        repeat (3) step();

        // Enable stall mid-flight stretches latency by exactly the stall length.
        drive_req(1'b1, 1'b0, 32'd1000, 32'd234, 1'b0);
        step();
        drive_req(1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
        step();
        clk_en = 1'b0;
        repeat (3) step();
        clk_en = 1'b1;
        wait_resp(cyc);
        check("stall_latency", 64'(cyc + 4), 64'(LAT + 1 + 3));
        check("stall_data", 64'(s_resp_data), 64'(1234));
        repeat (3) step();

        // Random traffic.
        for (int n = 0; n < 3000; n++) begin
            drive_req(1'($urandom_range(0, 1)), 1'($urandom_range(0, 7) == 0),
                      $urandom, $urandom, 1'($urandom_range(0, 19) == 0));
            t_resp_ready = ($urandom_range(0, 3) != 0);
            clk_en       = ($urandom_range(0, 9) != 0);
            spurious     = ($urandom_range(0, 7) == 0);
            step();
        end
        drive_req(1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
        t_resp_ready = 1'b1; clk_en = 1'b1; spurious = 1'b0;
        repeat (20) step();
        check("final_proto_err", 64'(dut.proto_err), 64'(m_proto));
        check("final_idle", 64'(t_resp_valid), 64'(0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/cfu_l2_target_shim.md
# cfu_l2_target_shim

Adapts a fixed-latency CFU-L1 leaf CFU, which has no ready and no backpressure, into a CFU-L2 target. It sits directly downstream of one target port of `switch_cfu_core`: it accepts that port's request stream and returns responses with full valid/ready handshaking. Backpressure is provided by a credit counter and a response FIFO, so an L1 response is never dropped while the switch stalls.

## Interface
Parameters:
- `CFU_CFU_ID_W`, `CFU_STATE_ID_W`, `CFU_FUNC_ID_W`, `CFU_INSN_W`, `CFU_DATA_W`, `CFU_STATUS_W`: defaults as `CFU_L2_PARAMS(1,1,10,0,32)`; CFU-LI widths.
- `LATENCY`, default 1: fixed L1 latency in enabled cycles; must be ≥1.
- `N_RESPS`, default 4: maximum requests in flight (pipe plus FIFO); also the FIFO depth; must be ≥1.

Ports:
- `clk` in 1: the single clock.
- `rst` in 1: reset, asynchronous, active-low.
- `clk_en` in 1: global enable; all state holds while it is low.
- `t_req_valid` in 1; `t_req_ready` out 1.
- `t_req_cfu` in `CFU_CFU_ID_W`; `t_req_state` in `CFU_STATE_ID_W`; `t_req_func` in `CFU_FUNC_ID_W`; `t_req_insn` in `CFU_INSN_W`; `t_req_data0`, `t_req_data1` in `CFU_DATA_W`.
- `t_resp_valid` out 1; `t_resp_ready` in 1; `t_resp_status` out `CFU_STATUS_W`; `t_resp_data` out `CFU_DATA_W`.
- `l1_clk_en` out 1: equals `clk_en`.
- `l1_req_valid` out 1; `l1_req_state`, `l1_req_func`, `l1_req_insn`, `l1_req_data0`, `l1_req_data1` out (request widths).
- `l1_resp_valid` in 1; `l1_resp_status` in `CFU_STATUS_W`; `l1_resp_data` in `CFU_DATA_W`.

## Operation
- **Credit counter.** `n_pend` is `$clog2(N_RESPS+1)` bits.
  - Update: +1 on a request handshake, −1 on a response handshake, unchanged when both occur.
  - `t_req_ready = clk_en && (n_pend != N_RESPS)`. There is no same-cycle pop bypass.
- **Dispatch.** On a request handshake with `t_req_cfu == 0`:
  - `l1_req_valid = 1` combinationally.
  - Request fields pass straight through to the L1 ports.
- **Bad CFU ID.** A handshake with `t_req_cfu != 0`:
  - Keeps `l1_req_valid = 0`.
  - Enters the pipe as a "bad" token.
- **Tracking pipe.** A `LATENCY`-deep shift register of {valid, bad} advances on each `clk_en` cycle.
- **Stage exit.** When a token leaves the last stage, the cycle in which the L1 response is due:
  - Good token with `l1_resp_valid == 1`: push {`l1_resp_status`, `l1_resp_data`}.
  - Good token with `l1_resp_valid == 0`: push {`CFU_ERROR`, 0} and set the sticky internal flag `proto_err`, which is cleared only by reset.
  - Bad token: push {`CFU_ERROR`, 0}.
  - `l1_resp_valid` with no token exiting: ignored.
- **Ordering.** Responses leave in request order, because both the pipe and the FIFO are FIFO-ordered.
- **Response FIFO.**
  - `t_resp_valid` is "FIFO not empty"; status and data are the FIFO head.
  - The head pops on a response handshake.
- **No overflow.** Credits guarantee the FIFO never overflows. Push to a full FIFO is impossible; the bench asserts this.

## Timing
- **Reset values.** While `rst` is low, all of the following are 0:
  - Outputs: `t_resp_valid`, `t_resp_status`, `t_resp_data`, `l1_req_valid`, `t_req_ready`.
  - State: `n_pend`, the pipe, the FIFO, `proto_err`.
- **Reset mid-operation.** All in-flight tokens and FIFO entries are discarded immediately. The first request is accepted on the first enabled edge after `rst` rises.
- **Latency.** For a request handshake in cycle 0:
  - The L1 sees it in cycle 0.
  - The push happens at the end of cycle `LATENCY`.
  - `t_resp_valid` is high in cycle `LATENCY+1`.
  - Total latency is `LATENCY+1` enabled cycles.
- **Throughput.** One request per cycle while `t_resp_ready` is high.
- **Full boundary.** At `n_pend == N_RESPS`, ready is low. A pop in cycle k raises ready in cycle k+1.
- **Simultaneous push and pop.** Allowed in the same cycle, on an empty or non-empty FIFO. On an empty FIFO the pushed entry is valid the next cycle (no fall-through).
- **`clk_en` low.** Handshakes are disabled (ready is forced low, and responses are not popped). The pipe and the FIFO freeze, and the L1 freezes via `l1_clk_en`.
- **Full round trip.** With `n_pend` at maximum, every in-flight response drains before the next acceptance.

## Structure
- `cfu_pkg` supplies the `CFU_L2_PARAMS` defaults and the `CFU_ERROR` status encoding. No new package types are needed.
- Local typedefs: `n_pend_t` (`$clog2(N_RESPS+1)` bits) and `resp_t` ({status, data}).
- The sub-module is the existing `queue` (`W = CFU_STATUS_W + CFU_DATA_W`, `N = N_RESPS`) used as the response FIFO. Its reset input is driven from the inverted `rst`.
- The tracking pipe and the credit counter are local logic.

## Test plan
- **Single request.** `LATENCY=2`, `N_RESPS=4`; request with data0=5, data1=7, L1 returning 12 two cycles later. Expect `t_resp_valid` in cycle 3 with data=12 and status from L1.
- **Back-to-back requests.** Four back-to-back requests with `t_resp_ready` held low. Expect ready low after the 4th. Then raise `t_resp_ready`: responses come out in order, one per cycle, and ready rises 1 cycle after the first pop.
- **Bad CFU ID.** Request with `t_req_cfu=1`. Expect no `l1_req_valid`, and a response with status=`CFU_ERROR`, data=0 at latency `LATENCY+1`, ordered correctly between good requests.
- **Missing L1 response.** L1 withholds `l1_resp_valid` at the due cycle. Expect an error response and `proto_err` set. Also inject a spurious `l1_resp_valid` with no token due: no push.
- **Reset with full state.** Drive `rst` low with 3 in flight and 1 queued. Expect all outputs 0 asynchronously. After release, the next request completes normally with `n_pend` back at 1.
- **Enable stall.** Toggle `clk_en` low for 3 cycles mid-flight. Expect latency extended by exactly 3 cycles, with data intact.
